// File: rtl/bench_stim_misr.sv
// Exhaustive stimulus sweep (binary or Gray order) for a combinational benchmark,
// with MISR compaction of its responses and an input toggle counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | out of reset, waiting for start
// APPLY   | stim driven, settle counter running down to terminal count
// CAPTURE | resp folded into the MISR, next vector issued
// DONE    | sweep complete, results held until the next start
module bench_stim_misr #(
    parameter int              IN_W       = 7,
    parameter int              OUT_W      = 10,
    parameter logic [OUT_W-1:0] MISR_POLY = 10'h009,
    parameter int              SETTLE_CYC = 1,
    parameter int              TCNT_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_gray,
    output logic [IN_W-1:0]   stim,
    input  logic [OUT_W-1:0]  resp,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  signature,
    output logic [IN_W:0]     vec_count,
    output logic [TCNT_W-1:0] toggle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [IN_W-1:0] LAST_IDX    = '1;
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t            state, state_nx;
    logic [IN_W-1:0]   idx;
    logic              gray_q;
    logic [3:0]        settle_cnt;
    logic              accept;
    logic [IN_W-1:0]   idx_nx;
    logic [IN_W-1:0]   stim_nx;
    logic [TCNT_W:0]   tc_sum;
    logic [TCNT_W-1:0] tc_sat;
    logic [OUT_W-1:0]  sig_nx;

    function automatic logic [IN_W-1:0] order(input logic [IN_W-1:0] x, input logic g);
        return g ? (x ^ (x >> 1)) : x;
    endfunction

    function automatic logic [TCNT_W:0] popcount(input logic [IN_W-1:0] x);
        logic [TCNT_W:0] c;
        c = '0;
        for (int i = 0; i < IN_W; i++) c = c + (TCNT_W+1)'(x[i]);
        return c;
    endfunction

    always_comb begin
        accept  = start && (state == S_IDLE || state == S_DONE);
        idx_nx  = idx + IN_W'(1);
        stim_nx = order(idx_nx, gray_q);
        tc_sum  = {1'b0, toggle_cnt} + popcount(stim ^ stim_nx);
        tc_sat  = tc_sum[TCNT_W] ? '1 : tc_sum[TCNT_W-1:0];
        sig_nx  = {signature[OUT_W-2:0], 1'b0}
                ^ (signature[OUT_W-1] ? MISR_POLY : '0)
                ^ resp;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_APPLY;
            end
            S_APPLY: begin
                busy = 1'b1;
                if (settle_cnt == 4'd0) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy     = 1'b1;
                state_nx = (idx == LAST_IDX) ? S_DONE : S_APPLY;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_APPLY;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            gray_q     <= 1'b0;
            settle_cnt <= '0;
            stim       <= '0;
            signature  <= '0;
            vec_count  <= '0;
            toggle_cnt <= '0;
        end else if (accept) begin
            // Reload to vector 0 is a fresh start, not switching activity.
            idx        <= '0;
            gray_q     <= mode_gray;
            settle_cnt <= SETTLE_LOAD;
            stim       <= '0;
            signature  <= '0;
            vec_count  <= '0;
            toggle_cnt <= '0;
        end else if (state == S_APPLY) begin
            if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end else if (state == S_CAPTURE) begin
            signature <= sig_nx;
            vec_count <= vec_count + (IN_W+1)'(1);
            if (idx != LAST_IDX) begin
                idx        <= idx_nx;
                stim       <= stim_nx;
                toggle_cnt <= tc_sat;
                settle_cnt <= SETTLE_LOAD;
            end
        end
    end

endmodule
